// File: rtl/mem_bus_pkg.sv
// Shared constants for the processor memory-bus controller: FSM state codes,
// region codes and the default address map.
package mem_bus_pkg;

  localparam int unsigned ST_W = 2;
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_WAIT   = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam int unsigned RG_W = 3;
  localparam logic [2:0] RG_ROM    = 3'd0;
  localparam logic [2:0] RG_RAM    = 3'd1;
  localparam logic [2:0] RG_IO_LED = 3'd2;
  localparam logic [2:0] RG_IO_SW  = 3'd3;
  localparam logic [2:0] RG_NONE   = 3'd4;

  localparam int unsigned DEF_RAM_BASE = 32'h0000_0100;
  localparam int unsigned DEF_IO_BASE  = 32'h0000_FF00;
  localparam int unsigned IO_LED_OFS   = 0;
  localparam int unsigned IO_SW_OFS    = 1;

  // ROM and RAM are the only regions whose reads go through the memory latency
  function automatic logic is_mem(input logic [2:0] rg);
    return (rg == RG_ROM) || (rg == RG_RAM);
  endfunction

endpackage

// File: rtl/mem_bus_decode.sv
// Combinational address decoder: region code, local word addresses and a
// legality flag for the access direction.
module mem_bus_decode
  import mem_bus_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned ROM_AW   = 8,
  parameter int unsigned RAM_AW   = 8,
  parameter int unsigned RAM_BASE = DEF_RAM_BASE,
  parameter int unsigned IO_BASE  = DEF_IO_BASE
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              w,
  output logic [RG_W-1:0]   region,
  output logic [ROM_AW-1:0] rom_word,
  output logic [RAM_AW-1:0] ram_word,
  output logic              legal
);

  localparam int unsigned ROM_SIZE = 32'd1 << ROM_AW;
  localparam int unsigned RAM_SIZE = 32'd1 << RAM_AW;

  logic [31:0] a;
  assign a = 32'(addr);

  // Regions never overlap, so the tests are independent rather than prioritised
  always_comb begin
    region = RG_NONE;
    if (a < ROM_SIZE)                                region = RG_ROM;
    if ((a >= RAM_BASE) && (a < RAM_BASE + RAM_SIZE)) region = RG_RAM;
    if (a == IO_BASE + IO_LED_OFS)                   region = RG_IO_LED;
    if (a == IO_BASE + IO_SW_OFS)                    region = RG_IO_SW;
  end

  assign rom_word = ROM_AW'(addr);
  assign ram_word = RAM_AW'(a - RAM_BASE);
  assign legal    = (region != RG_NONE) &&
                    !(w && ((region == RG_ROM) || (region == RG_IO_SW)));

endmodule

// File: rtl/mem_bus_ctrl.sv
// Memory-bus controller: accepts one processor access at a time, hides the
// memory read latency and returns a single-cycle Ready (with BusErr on illegal).
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned ROM_AW   = 8,
  parameter int unsigned RAM_AW   = 8,
  parameter int unsigned RAM_BASE = DEF_RAM_BASE,
  parameter int unsigned IO_BASE  = DEF_IO_BASE,
  parameter int unsigned READ_LAT = 1
) (
  input  logic              Clock,
  input  logic              Resetn,
  input  logic              Req,
  input  logic              W,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DOut,
  output logic [DATA_W-1:0] DIn,
  output logic              Ready,
  output logic              BusErr,
  output logic [ROM_AW-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_q,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  input  logic [DATA_W-1:0] SW,
  output logic [DATA_W-1:0] LEDR
);

  localparam int unsigned CNT_W    = 3;
  localparam logic        HAS_LAT  = (READ_LAT != 0);
  localparam logic [2:0]  LAT_LOAD = CNT_W'((READ_LAT == 0) ? 0 : READ_LAT - 1);

  logic [ST_W-1:0]   state, state_d;
  logic [RG_W-1:0]   region_q;
  logic              legal_q;
  logic              w_q;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] sw_meta, sw_sync;

  logic [RG_W-1:0]   dec_region;
  logic [ROM_AW-1:0] dec_rom;
  logic [RAM_AW-1:0] dec_ram;
  logic              dec_legal;
  logic              accept;
  logic              mem_rd;

  // Decode the address as it is latched so region and local addresses are
  // registered together and stay stable from ACCESS through RESP.
  mem_bus_decode #(
    .ADDR_W   (ADDR_W),
    .ROM_AW   (ROM_AW),
    .RAM_AW   (RAM_AW),
    .RAM_BASE (RAM_BASE),
    .IO_BASE  (IO_BASE)
  ) u_decode (
    .addr     (Addr),
    .w        (W),
    .region   (dec_region),
    .rom_word (dec_rom),
    .ram_word (dec_ram),
    .legal    (dec_legal)
  );

  assign accept = (state == ST_IDLE) && Req;
  assign mem_rd = legal_q && !w_q && is_mem(region_q);

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) state <= ST_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:   if (Req) state_d = ST_ACCESS;
      ST_ACCESS: state_d = (mem_rd && HAS_LAT) ? ST_WAIT : ST_RESP;
      ST_WAIT:   if (cnt == '0) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Two-flop synchroniser for the asynchronous switches
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW;
      sw_sync <= sw_meta;
    end
  end

  // Access latches and memory-port drive
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      region_q <= RG_NONE;
      legal_q  <= 1'b0;
      w_q      <= 1'b0;
      rom_addr <= '0;
      ram_addr <= '0;
      ram_data <= '0;
      ram_wren <= 1'b0;
    end else begin
      ram_wren <= accept && W && dec_legal && (dec_region == RG_RAM);
      if (accept) begin
        region_q <= dec_region;
        legal_q  <= dec_legal;
        w_q      <= W;
        rom_addr <= dec_rom;
        ram_addr <= dec_ram;
        ram_data <= DOut;
      end
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      cnt <= '0;
    end else if ((state == ST_ACCESS) && (state_d == ST_WAIT)) begin
      cnt <= LAT_LOAD;
    end else if ((state == ST_WAIT) && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      LEDR <= '0;
    end else if ((state == ST_ACCESS) && legal_q && w_q && (region_q == RG_IO_LED)) begin
      LEDR <= ram_data;
    end
  end

  // Read-data capture: IO and zero-latency memory at the end of ACCESS,
  // latent memory reads when the WAIT countdown expires.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      DIn <= '0;
    end else if ((state == ST_ACCESS) && !w_q) begin
      if (!legal_q) begin
        DIn <= '0;
      end else begin
        case (region_q)
          RG_IO_LED: DIn <= LEDR;
          RG_IO_SW:  DIn <= sw_sync;
          RG_ROM:    if (!HAS_LAT) DIn <= rom_q;
          RG_RAM:    if (!HAS_LAT) DIn <= ram_q;
          default:   ;
        endcase
      end
    end else if ((state == ST_WAIT) && (cnt == '0)) begin
      DIn <= (region_q == RG_ROM) ? rom_q : ram_q;
    end
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      Ready  <= 1'b0;
      BusErr <= 1'b0;
    end else begin
      Ready  <= (state_d == ST_RESP);
      BusErr <= (state_d == ST_RESP) && !legal_q;
    end
  end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Bench for mem_bus_ctrl: two instances (READ_LAT 1 and 3) with behavioural
// ROM/RAM stand-ins, checked against an address-map reference model.
module tb_mem_bus_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req      [2];
  logic        w        [2];
  logic [15:0] addr     [2];
  logic [15:0] dout     [2];
  logic [15:0] din      [2];
  logic        ready    [2];
  logic        buserr   [2];
  logic [7:0]  rom_addr [2];
  logic [15:0] rom_q    [2];
  logic [7:0]  ram_addr [2];
  logic [15:0] ram_data [2];
  logic        ram_wren [2];
  logic [15:0] ram_q    [2];
  logic [15:0] ledr     [2];
  logic [15:0] sw;

  int errors = 0;
  int checks = 0;

  logic [15:0] m_ram [2][256];
  logic [15:0] m_led [2];
  logic [15:0] m_din [2];

  always #5 clk = ~clk;

  mem_bus_ctrl #(.READ_LAT(1)) u_dut0 (
    .Clock(clk), .Resetn(rst_n), .Req(req[0]), .W(w[0]), .Addr(addr[0]),
    .DOut(dout[0]), .DIn(din[0]), .Ready(ready[0]), .BusErr(buserr[0]),
    .rom_addr(rom_addr[0]), .rom_q(rom_q[0]), .ram_addr(ram_addr[0]),
    .ram_data(ram_data[0]), .ram_wren(ram_wren[0]), .ram_q(ram_q[0]),
    .SW(sw), .LEDR(ledr[0])
  );

  mem_bus_ctrl #(.READ_LAT(3)) u_dut1 (
    .Clock(clk), .Resetn(rst_n), .Req(req[1]), .W(w[1]), .Addr(addr[1]),
    .DOut(dout[1]), .DIn(din[1]), .Ready(ready[1]), .BusErr(buserr[1]),
    .rom_addr(rom_addr[1]), .rom_q(rom_q[1]), .ram_addr(ram_addr[1]),
    .ram_data(ram_data[1]), .ram_wren(ram_wren[1]), .ram_q(ram_q[1]),
    .SW(sw), .LEDR(ledr[1])
  );

  function automatic logic [15:0] rom_val(input logic [7:0] a);
    return {a ^ 8'hC3, a};
  endfunction

  function automatic int lat_of(input int i);
    return (i == 0) ? 1 : 3;
  endfunction

  // 0 ROM, 1 RAM, 2 LED, 3 SW, 4 unmapped
  function automatic int region_of(input logic [15:0] a);
    if (a < 16'h0100) return 0;
    if (a < 16'h0200) return 1;
    if (a == 16'hFF00) return 2;
    if (a == 16'hFF01) return 3;
    return 4;
  endfunction

  function automatic bit legal_of(input int rg, input bit wr);
    return (rg != 4) && !(wr && (rg == 0 || rg == 3));
  endfunction

  // Memory stand-ins: registered read pipelines of depth READ_LAT
  for (genvar g = 0; g < 2; g++) begin : g_mem
    localparam int L = (g == 0) ? 1 : 3;
    logic [15:0] rpipe [L];
    logic [15:0] qpipe [L];
    logic [15:0] mem   [256];
    initial for (int k = 0; k < 256; k++) mem[k] <= 16'h0;
    always @(posedge clk) begin
      if (ram_wren[g]) mem[ram_addr[g]] <= ram_data[g];
      rpipe[0] <= rom_val(rom_addr[g]);
      qpipe[0] <= mem[ram_addr[g]];
      for (int k = 1; k < L; k++) begin
        rpipe[k] <= rpipe[k-1];
        qpipe[k] <= qpipe[k-1];
      end
    end
    assign rom_q[g] = rpipe[L-1];
    assign ram_q[g] = qpipe[L-1];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One processor access on instance i; poke pulses a stray Req in cycle 3
  task automatic access(input int i, input bit wr, input logic [15:0] a,
                        input logic [15:0] d, input bit poke);
    int rg, exp_cyc, idx;
    bit lg;
    int rdy_cyc, rdy_cnt, wren_cnt, wren_cyc;
    logic [15:0] led_c2;
    rg = region_of(a);
    lg = legal_of(rg, wr);
    idx = int'(a) - 256;
    exp_cyc = (!wr && lg && rg < 2) ? 2 + lat_of(i) : 2;
    if (!wr) begin
      if (!lg)          m_din[i] = 16'h0;
      else if (rg == 0) m_din[i] = rom_val(a[7:0]);
      else if (rg == 1) m_din[i] = m_ram[i][idx];
      else if (rg == 2) m_din[i] = m_led[i];
      else              m_din[i] = sw;
    end else if (lg) begin
      if (rg == 1) m_ram[i][idx] = d;
      if (rg == 2) m_led[i] = d;
    end
    rdy_cyc = -1; rdy_cnt = 0; wren_cnt = 0; wren_cyc = -1; led_c2 = 16'hxxxx;
    @(posedge clk); #1;
    req[i] = 1'b1; w[i] = wr; addr[i] = a; dout[i] = d;
    for (int c = 0; c < 12; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        req[i] = poke && (c == 3);
        if (poke && c == 3) begin
          w[i] = 1'b1; addr[i] = 16'h0105; dout[i] = 16'hFFFF;
        end
      end
      @(negedge clk);
      if (ready[i]) begin
        rdy_cnt++;
        if (rdy_cyc < 0) begin
          rdy_cyc = c;
          check("buserr", 32'(buserr[i]), 32'(!lg));
          check("din", 32'(din[i]), 32'(m_din[i]));
          if (rg == 1) check("ram_addr", 32'(ram_addr[i]), 32'(a[7:0]));
          if (rg == 0) check("rom_addr", 32'(rom_addr[i]), 32'(a[7:0]));
        end
      end
      if (ram_wren[i]) begin
        wren_cnt++;
        wren_cyc = c;
      end
      if (c == 2) led_c2 = ledr[i];
      if (rdy_cyc >= 0 && c >= rdy_cyc + 2) break;
    end
    check("ready_cycle", 32'(rdy_cyc), 32'(exp_cyc));
    check("ready_pulses", 32'(rdy_cnt), 32'd1);
    check("wren_count", 32'(wren_cnt), (wr && lg && rg == 1) ? 32'd1 : 32'd0);
    if (wr && lg && rg == 1) check("wren_cycle", 32'(wren_cyc), 32'd1);
    check("led_c2", 32'(led_c2), 32'(m_led[i]));
    check("din_after", 32'(din[i]), 32'(m_din[i]));
  endtask

  task automatic check_reset_outputs(input int i);
    check("rst_din", 32'(din[i]), 32'h0);
    check("rst_ledr", 32'(ledr[i]), 32'h0);
    check("rst_ready", 32'(ready[i]), 32'h0);
    check("rst_buserr", 32'(buserr[i]), 32'h0);
    check("rst_wren", 32'(ram_wren[i]), 32'h0);
    check("rst_ram_addr", 32'(ram_addr[i]), 32'h0);
    check("rst_rom_addr", 32'(rom_addr[i]), 32'h0);
    check("rst_ram_data", 32'(ram_data[i]), 32'h0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int rdy_seen;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 256; k++) m_ram[i][k] = 16'h0;
      m_led[i] = 16'h0; m_din[i] = 16'h0;
      req[i] = 1'b1; w[i] = 1'b0; addr[i] = 16'h0; dout[i] = 16'h0;
    end
    sw = 16'h0;
    rst_n = 1'b0;

    // Reset with Req held high never produces Ready
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rst_hold_ready0", 32'(ready[0]), 32'h0);
      check("rst_hold_ready1", 32'(ready[1]), 32'h0);
    end
    @(posedge clk); #1;
    req[0] = 1'b0; req[1] = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs(0);
    check_reset_outputs(1);

    // RAM write then read-back (latency 1)
    access(0, 1'b1, 16'h0105, 16'hBEEF, 1'b0);
    access(0, 1'b0, 16'h0105, 16'h0000, 1'b0);
    // ROM read with latency 3 and a stray Req during WAIT
    access(1, 1'b0, 16'h0003, 16'h0000, 1'b1);
    repeat (4) begin
      @(negedge clk);
      check("stray_req_ready", 32'(ready[1]), 32'h0);
    end
    // LED write, switch read
    access(0, 1'b1, 16'hFF00, 16'h00A5, 1'b0);
    sw = 16'h1234;
    repeat (3) @(posedge clk);
    access(0, 1'b0, 16'hFF01, 16'h0000, 1'b0);
    access(0, 1'b0, 16'hFF00, 16'h0000, 1'b0);
    // Illegal accesses
    access(0, 1'b1, 16'h0000, 16'h5555, 1'b0);
    access(0, 1'b0, 16'h8000, 16'h0000, 1'b0);
    access(0, 1'b1, 16'hFF01, 16'h7777, 1'b0);
    access(0, 1'b0, 16'h0000, 16'h0000, 1'b0);

    // Randomised traffic on both instances
    for (int n = 0; n < 60; n++) begin
      int i, kind;
      logic [15:0] a;
      i = int'($urandom_range(0, 1));
      kind = int'($urandom_range(0, 5));
      case (kind)
        0:       a = 16'($urandom_range(0, 255));
        1, 5:    a = 16'h0100 + 16'($urandom_range(0, 15));
        2:       a = 16'hFF00;
        3:       a = 16'hFF01;
        default: a = 16'h0200 + 16'($urandom_range(0, 32'hFCFF));
      endcase
      if ((n % 8) == 0) begin
        sw = 16'($urandom);
        repeat (3) @(posedge clk);
      end
      access(i, 1'($urandom_range(0, 1)), a, 16'($urandom), 1'b0);
    end

    // Reset during WAIT of a RAM read aborts without Ready
    access(1, 1'b1, 16'h0107, 16'hCAFE, 1'b0);
    @(posedge clk); #1;
    req[1] = 1'b1; w[1] = 1'b0; addr[1] = 16'h0107;
    @(posedge clk); #1;
    req[1] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    m_led[0] = 16'h0; m_led[1] = 16'h0; m_din[0] = 16'h0; m_din[1] = 16'h0;
    @(negedge clk);
    check_reset_outputs(1);
    check_reset_outputs(0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    rdy_seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (ready[1] || ready[0]) rdy_seen++;
    end
    check("abort_no_ready", 32'(rdy_seen), 32'h0);
    access(1, 1'b0, 16'h0107, 16'h0000, 1'b0);
    access(0, 1'b0, 16'h0105, 16'h0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
